// File: rtl/conv3x3_engine.sv
// conv3x3_engine: walks every valid 3x3 window of an image held in an
// external single-port RAM, forms a signed weighted sum of the nine pixels,
// normalises it by an arithmetic right shift, clamps it to 0..255 and writes
// it back in place at the window's top-left address.
// Optional build macro CONV_ABS_EN: clamp the magnitude of the sum instead of
// the signed sum, which suits edge-detection kernels.
module conv3x3_engine #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [71:0]       kernel,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] address,
    output logic              r_en,
    output logic              w_en,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done
);

    localparam int COEF_W = 8;
    localparam int ACC_W  = 20;
    localparam int PROD_W = DATA_W + COEF_W + 1;

    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 3);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   row;
    logic [ADDR_W-1:0]   col;
    logic [3:0]          tap;
    logic signed [COEF_W-1:0] coefs [0:8];

    logic                vld_p1;
    logic [3:0]          tap_p1;
    logic signed [COEF_W-1:0] coef_p1;
    logic signed [DATA_W:0]   pix_p1;
    logic signed [PROD_W-1:0] prod_p1;
    logic signed [ACC_W-1:0]  sum_p1;
    logic signed [ACC_W-1:0]  acc_p2;

    // RAM address of tap t of the window whose top-left pixel is (r, c)
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] r,
                                                   input logic [ADDR_W-1:0] c,
                                                   input logic [3:0]        t);
        logic [ADDR_W-1:0] dr;
        logic [ADDR_W-1:0] dc;
        dr = ADDR_W'(t / 4'd3);
        dc = ADDR_W'(t % 4'd3);
        return (r + dr) * IMG_W_A + c + dc;
    endfunction

    // Shift-normalise and clamp a window sum into the unsigned pixel range
    function automatic logic [DATA_W-1:0] sat_pix(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] mag;
        logic signed [ACC_W-1:0] shifted;
`ifdef CONV_ABS_EN
        mag = (a < 0) ? -a : a;
`else
        mag = a;
`endif
        shifted = mag >>> SHIFT;
        if (shifted < 0)
            return '0;
        else if (shifted > PIX_MAX)
            return '1;
        else
            return shifted[DATA_W-1:0];
    endfunction

    // ---- stage p1: RAM data for the tap issued last cycle is present ----
    // Multiply the returned pixel by its coefficient and fold it into the sum
    always_comb begin
        coef_p1 = coefs[tap_p1];
        pix_p1  = $signed({1'b0, mem_rdata});
        prod_p1 = PROD_W'(pix_p1) * PROD_W'(coef_p1);
        if (tap_p1 == 4'd0)
            sum_p1 = ACC_W'(prod_p1);
        else
            sum_p1 = acc_p2 + ACC_W'(prod_p1);
    end

    // Tap valid follows the read enable by one cycle, matching RAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= r_en;
    end

    // ---- stage p2: kernel latch, tap tag and accumulator (data only) ----
    // Datapath registers carry no reset; vld_p1 gates every accumulator update
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            for (int k = 0; k < 9; k++)
                coefs[k] <= kernel[COEF_W*k +: COEF_W];
        end
        tap_p1 <= tap;
        if (vld_p1)
            acc_p2 <= sum_p1;
    end

    // Window sequencer; every RAM-facing output is registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            tap     <= '0;
            address <= '0;
            r_en    <= 1'b0;
            w_en    <= 1'b0;
            wdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row     <= '0;
                        col     <= '0;
                        tap     <= '0;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        r_en    <= 1'b1;
                        address <= '0;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (tap == 4'd8) begin
                        r_en  <= 1'b0;
                        state <= WAIT;
                    end else begin
                        tap     <= tap + 4'd1;
                        address <= tap_addr(row, col, tap + 4'd1);
                    end
                end
                WAIT: begin
                    // The last tap's product is folded in on the way to wdata
                    w_en    <= 1'b1;
                    address <= row * IMG_W_A + col;
                    wdata   <= sat_pix(sum_p1);
                    state   <= WRITE;
                end
                WRITE: begin
                    w_en <= 1'b0;
                    tap  <= '0;
                    if (col == LAST_COL) begin
                        col <= '0;
                        if (row == LAST_ROW) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            row     <= row + 1'b1;
                            r_en    <= 1'b1;
                            address <= tap_addr(row + 1'b1, '0, 4'd0);
                            state   <= READ;
                        end
                    end else begin
                        col     <= col + 1'b1;
                        r_en    <= 1'b1;
                        address <= tap_addr(row, col + 1'b1, 4'd0);
                        state   <= READ;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine on a small non-square 8x6 image with a
// behavioural RAM (registered read, one-cycle latency). Expected pixels are
// hand-derived from the loaded pattern.
module tb_conv3x3_engine;

    localparam int W        = 8;
    localparam int H        = 6;
    localparam int AW       = 12;
    localparam int DW       = 8;
    localparam int SH       = 4;
    localparam int PASS_CYC = (W - 2) * (H - 2) * 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [71:0]   kernel = '0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] address;
    logic          r_en;
    logic          w_en;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem  [0:(1<<AW)-1];
    int            orig [0:W*H-1];

    int   checks   = 0;
    int   failures = 0;
    logic overlap  = 1'b0;
    logic idle_bad = 1'b0;

    always #5 clk = ~clk;

    conv3x3_engine #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW), .SHIFT(SH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kernel(kernel),
        .mem_rdata(mem_rdata), .address(address), .r_en(r_en), .w_en(w_en),
        .wdata(wdata), .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        if (w_en) mem[address] <= wdata;
        if (r_en) mem_rdata <= mem[address];
    end

    always @(negedge clk) begin
        if (r_en && w_en) overlap = 1'b1;
        if (!busy && (r_en || w_en)) idle_bad = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] kern9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
        logic [71:0] k;
        int v [9];
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int i = 0; i < 9; i++) k[8*i +: 8] = v[i][7:0];
        return k;
    endfunction

    task automatic load_const(input int v);
        for (int i = 0; i < W*H; i++) begin
            mem[i]  <= v[7:0];
            orig[i] = v;
        end
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < W*H; i++) begin
            orig[i] = (i / W) * 16 + (i % W);
            mem[i]  <= 8'(orig[i]);
        end
        #1;
    endtask

    task automatic check_img(input string tag, input bit use_off, input int dr,
                             input int dc, input int val);
        int exp;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < H - 2 && c < W - 2)
                    exp = use_off ? orig[(r + dr) * W + c + dc] : val;
                else
                    exp = orig[r * W + c];
                chk($sformatf("%s[%0d,%0d]", tag, r, c), 32'(mem[r * W + c]), exp);
            end
        end
    endtask

    task automatic run_pass(input logic [71:0] k, input int restart_at,
                            input logic [71:0] k2, input string tag);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1;
        kernel = k;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_on"}, 32'(busy), 1);
        chk({tag, "_done_clr"}, 32'(done), 0);
        chk({tag, "_ren0"}, 32'(r_en), 1);
        chk({tag, "_addr0"}, 32'(address), 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < PASS_CYC + 20) begin
            if (cyc == restart_at) begin
                start = 1'b1;
                kernel = k2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc == restart_at + 1) chk({tag, "_restart_busy"}, 32'(busy), 1);
        end
        chk({tag, "_latency"}, cyc, PASS_CYC);
        chk({tag, "_busy_off"}, 32'(busy), 0);
    endtask

    initial begin
        int n;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_address", 32'(address), 0);
        chk("rst_r_en", 32'(r_en), 0);
        chk("rst_w_en", 32'(w_en), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_r_en", 32'(r_en), 0);

        // Smoothing kernel on a flat image
        load_const(100);
        run_pass(kern9(1, 2, 1, 2, 4, 2, 1, 2, 1), -1, '0, "smooth");
        chk("smooth_done_level", 32'(done), 1);
        check_img("smooth", 1'b0, 0, 0, 100);

        // Single-tap kernels on a ramp pick out one neighbour each
        load_ramp();
        run_pass(kern9(0, 0, 0, 0, 16, 0, 0, 0, 0), -1, '0, "ident");
        check_img("ident", 1'b1, 1, 1, 0);
        load_ramp();
        run_pass(kern9(0, 0, 0, 0, 0, 0, 16, 0, 0), -1, '0, "k6");
        check_img("k6", 1'b1, 2, 0, 0);
        load_ramp();
        run_pass(kern9(0, 0, 16, 0, 0, 0, 0, 0, 0), -1, '0, "k2");
        check_img("k2", 1'b1, 0, 2, 0);

        // Vertical gradient: +128 -> 8; negated -128 -> 0 (or 8 as magnitude)
        load_ramp();
        run_pass(kern9(-1, -2, -1, 0, 0, 0, 1, 2, 1), -1, '0, "grad");
        check_img("grad", 1'b0, 0, 0, 8);
        load_ramp();
        run_pass(kern9(1, 2, 1, 0, 0, 0, -1, -2, -1), -1, '0, "ngrad");
`ifdef CONV_ABS_EN
        check_img("ngrad", 1'b0, 0, 0, 8);
`else
        check_img("ngrad", 1'b0, 0, 0, 0);
`endif

        // Upper clamp: 291465 >> 4 = 18216 -> 255
        load_const(255);
        run_pass(kern9(127, 127, 127, 127, 127, 127, 127, 127, 127), -1, '0, "sat");
        check_img("sat", 1'b0, 0, 0, 255);

        // Negative sum: -450 -> 0, or 450 >> 4 = 28 as magnitude
        load_const(50);
        run_pass(kern9(-1, -1, -1, -1, -1, -1, -1, -1, -1), -1, '0, "neg");
`ifdef CONV_ABS_EN
        check_img("neg", 1'b0, 0, 0, 28);
`else
        check_img("neg", 1'b0, 0, 0, 0);
`endif

        // Start pulsed mid-pass with another kernel is ignored
        load_const(100);
        run_pass(kern9(1, 2, 1, 2, 4, 2, 1, 2, 1), 30,
                 kern9(127, 127, 127, 127, 127, 127, 127, 127, 127), "restart");
        check_img("restart", 1'b0, 0, 0, 100);

        // Reset asserted during the first WRITE cycle abandons the write
        load_const(100);
        @(posedge clk); #1;
        start = 1'b1;
        kernel = kern9(-1, -1, -1, -1, -1, -1, -1, -1, -1);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (w_en !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_seen", 32'(w_en), 1);
        chk("wr_cycle", n, 10);
        chk("wr_addr", 32'(address), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_w_en", 32'(w_en), 0);
        chk("mid_rst_r_en", 32'(r_en), 0);
        chk("mid_rst_address", 32'(address), 0);
        chk("mid_rst_wdata", 32'(wdata), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        @(posedge clk); #1;
        chk("wr_abandoned", 32'(mem[0]), 100);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_r_en", 32'(r_en), 0);

        // Full rerun after the reset
        load_ramp();
        run_pass(kern9(0, 0, 0, 0, 16, 0, 0, 0, 0), -1, '0, "rerun");
        check_img("rerun", 1'b1, 1, 1, 0);

        chk("rw_overlap", 32'(overlap), 0);
        chk("idle_enables", 32'(idle_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
